// File: rtl/victim_pkg.sv
// Shared widths and entry layout for the victim fill buffer.
// The lookup bypass is enabled with the VFB_BYPASS_EN macro.
package victim_pkg;

   localparam int TAG_W  = 44;
   localparam int IDX_W  = 6;
   localparam int DATA_W = 512;
   localparam int OFF_W  = 6;

   typedef logic [DATA_W-1:0] blk_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] index;
      blk_t             data;
   } vfb_entry_t;

   // Byte 0 lives in bits [7:0]; offset counts bytes upward.
   function automatic logic [7:0] blk_byte(input blk_t blk, input logic [OFF_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/vfb_match.sv
// Lookup bypass for the victim fill buffer: compares a lookup against every
// live slot and returns one byte of the youngest matching entry.
// Only instantiated when VFB_BYPASS_EN is defined.
module vfb_match
   import victim_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  vfb_entry_t                   entries_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]     rd_ptr_i,
   input  logic [$clog2(DEPTH):0]       count_i,
   input  logic [TAG_W-1:0]             lk_tag_i,
   input  logic [IDX_W-1:0]             lk_index_i,
   input  logic [OFF_W-1:0]             lk_offset_i,
   output logic                         hit_o,
   output logic [7:0]                   byte_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] slot;

   // Walk slots oldest to youngest so a later (younger) match overrides an older one.
   always_comb begin
      hit_o  = 1'b0;
      byte_o = 8'h00;
      slot   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr_i + PW'(k);
         if ((CW'(k) < count_i) &&
             (entries_i[slot].tag == lk_tag_i) &&
             (entries_i[slot].index == lk_index_i)) begin
            hit_o  = 1'b1;
            byte_o = blk_byte(entries_i[slot].data, lk_offset_i);
         end
      end
   end

endmodule

// File: rtl/victim_fill_buffer.sv
// Eviction FIFO between the L1 dcache and the victim cache. Captures evicted
// blocks over valid/ready and drains one per cycle unless the victim cache
// holds its write port for a lookup.
// Optional feature: VFB_BYPASS_EN adds a combinational lookup into buffered entries.
module victim_fill_buffer
   import victim_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       evict_valid,
   output logic                       evict_ready,
   input  logic [TAG_W-1:0]           evict_tag,
   input  logic [IDX_W-1:0]           evict_index,
   input  logic [DATA_W-1:0]          evict_data,
   input  logic                       vc_hold,
   output logic                       vc_write_en,
   output logic [TAG_W-1:0]           vc_tag,
   output logic [IDX_W-1:0]           vc_index,
   output logic [DATA_W-1:0]          vc_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     occupancy,
   input  logic [TAG_W-1:0]           lk_tag,
   input  logic [IDX_W-1:0]           lk_index,
   input  logic [OFF_W-1:0]           lk_offset,
   output logic                       lk_hit,
   output logic [7:0]                 lk_byte
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          enq;
   logic          deq;
   vfb_entry_t    entry_arr [DEPTH];
   vfb_entry_t    head;

   // Ready is a pure function of fill level; held low while reset is asserted.
   assign evict_ready = !reset && (count_q != CW'(DEPTH));
   // A flush swallows any concurrent enqueue and suppresses the drain.
   assign enq         = evict_valid && evict_ready && !flush;
   assign vc_write_en = (count_q != '0) && !vc_hold && !flush;
   assign deq         = vc_write_en;
   assign occupancy   = count_q;

   // Per-slot storage; only the slot under the write pointer loads on enqueue.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      vfb_entry_t slot_q;

      // Capture the evicted block into this slot.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            slot_q <= '0;
         end else if (enq && (wr_ptr_q == PW'(gi))) begin
            slot_q <= '{tag: evict_tag, index: evict_index, data: evict_data};
         end
      end

      assign entry_arr[gi] = slot_q;
   end

   // Head entry is always visible to the victim cache write port.
   assign head     = entry_arr[rd_ptr_q];
   assign vc_tag   = head.tag;
   assign vc_index = head.index;
   assign vc_data  = head.data;

   // Next pointer and count; simultaneous enqueue and drain leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
         if (enq && !deq) begin
            count_d = count_q + CW'(1);
         end else if (!enq && deq) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef VFB_BYPASS_EN
   vfb_match #(
      .DEPTH (DEPTH)
   ) u_match (
      .entries_i   (entry_arr),
      .rd_ptr_i    (rd_ptr_q),
      .count_i     (count_q),
      .lk_tag_i    (lk_tag),
      .lk_index_i  (lk_index),
      .lk_offset_i (lk_offset),
      .hit_o       (lk_hit),
      .byte_o      (lk_byte)
   );
`else
   logic unused_lk;
   assign unused_lk = ^{lk_tag, lk_index, lk_offset};
   assign lk_hit    = 1'b0;
   assign lk_byte   = 8'h00;
`endif

endmodule

// File: tb/tb_victim_fill_buffer.sv
// Self-checking bench for victim_fill_buffer: queue-based reference model
// checked every falling edge, plus directed literal expectations.
module tb_victim_fill_buffer;
   import victim_pkg::*;

   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 evict_valid;
   logic                 evict_ready;
   logic [TAG_W-1:0]     evict_tag;
   logic [IDX_W-1:0]     evict_index;
   logic [DATA_W-1:0]    evict_data;
   logic                 vc_hold;
   logic                 vc_write_en;
   logic [TAG_W-1:0]     vc_tag;
   logic [IDX_W-1:0]     vc_index;
   logic [DATA_W-1:0]    vc_data;
   logic                 flush;
   logic [2:0]           occupancy;
   logic [TAG_W-1:0]     lk_tag;
   logic [IDX_W-1:0]     lk_index;
   logic [OFF_W-1:0]     lk_offset;
   logic                 lk_hit;
   logic [7:0]           lk_byte;

   int n_vec = 0;
   int n_err = 0;

   vfb_entry_t      model_q[$];
   logic [TAG_W-1:0] drained[$];

   victim_fill_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .evict_valid (evict_valid),
      .evict_ready (evict_ready),
      .evict_tag   (evict_tag),
      .evict_index (evict_index),
      .evict_data  (evict_data),
      .vc_hold     (vc_hold),
      .vc_write_en (vc_write_en),
      .vc_tag      (vc_tag),
      .vc_index    (vc_index),
      .vc_data     (vc_data),
      .flush       (flush),
      .occupancy   (occupancy),
      .lk_tag      (lk_tag),
      .lk_index    (lk_index),
      .lk_offset   (lk_offset),
      .lk_hit      (lk_hit),
      .lk_byte     (lk_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic blk_t mk_data(input logic [TAG_W-1:0] tag);
      blk_t d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = tag[31:0] ^ (32'h01010101 * i) ^ 32'hA5000000;
      return d;
   endfunction

   // Reference model: expected outputs from the FIFO contents, then advance on the coming edge.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_ready", 576'(evict_ready), 576'(0));
         chk("rst_we",    576'(vc_write_en), 576'(0));
         chk("rst_occ",   576'(occupancy),   576'(0));
         chk("rst_tag",   576'(vc_tag),      576'(0));
         chk("rst_hit",   576'(lk_hit),      576'(0));
         model_q.delete();
      end else begin
         int   n;
         logic exp_ready, exp_we, exp_hit;
         logic [7:0] exp_byte;
         n         = model_q.size();
         exp_ready = (n != DEPTH);
         exp_we    = (n != 0) && !vc_hold && !flush;
         exp_hit   = 1'b0;
         exp_byte  = 8'h00;
`ifdef VFB_BYPASS_EN
         foreach (model_q[k]) begin
            if (model_q[k].tag == lk_tag && model_q[k].index == lk_index) begin
               exp_hit  = 1'b1;
               exp_byte = model_q[k].data[lk_offset*8 +: 8];
            end
         end
`endif
         chk("ready", 576'(evict_ready), 576'(exp_ready));
         chk("we",    576'(vc_write_en), 576'(exp_we));
         chk("occ",   576'(occupancy),   576'(n));
         chk("hit",   576'(lk_hit),      576'(exp_hit));
         chk("byte",  576'(lk_byte),     576'(exp_byte));
         if (n != 0) begin
            chk("head_tag",  576'(vc_tag),   576'(model_q[0].tag));
            chk("head_idx",  576'(vc_index), 576'(model_q[0].index));
            chk("head_data", 576'(vc_data),  576'(model_q[0].data));
         end
         if (flush) begin
            model_q.delete();
         end else begin
            if (exp_we) begin
               $display("drain tag=%0h idx=%0h", model_q[0].tag, model_q[0].index);
               drained.push_back(vc_tag);
               void'(model_q.pop_front());
            end
            if (evict_valid && exp_ready)
               model_q.push_back('{tag: evict_tag, index: evict_index, data: evict_data});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx, input blk_t d);
      evict_valid = 1'b1;
      evict_tag   = tag;
      evict_index = idx;
      evict_data  = d;
      cyc();
      evict_valid = 1'b0;
   endtask

   initial begin
      blk_t d;
      reset       = 1'b1;
      evict_valid = 1'b0;
      evict_tag   = '0;
      evict_index = '0;
      evict_data  = '0;
      vc_hold     = 1'b0;
      flush       = 1'b0;
      lk_tag      = '0;
      lk_index    = '0;
      lk_offset   = '0;
      #2;
      chk("t0_ready_in_reset", 576'(evict_ready), 576'(0));
      chk("t0_we_in_reset",    576'(vc_write_en), 576'(0));
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("t0_ready_after", 576'(evict_ready), 576'(1));
      chk("t0_occ_after",   576'(occupancy),   576'(0));

      // 1: fill under hold
      vc_hold = 1'b1;
      for (int i = 1; i <= 4; i++) enq(TAG_W'(i), IDX_W'(i), mk_data(TAG_W'(i)));
      chk("t1_occ",   576'(occupancy),   576'(4));
      chk("t1_ready", 576'(evict_ready), 576'(0));
      chk("t1_we",    576'(vc_write_en), 576'(0));

      // 2: release hold, four back-to-back drains in order
      vc_hold = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk("t2_we",  576'(vc_write_en), 576'(1));
         chk("t2_tag", 576'(vc_tag),      576'(i));
         chk("t2_ready_full", 576'(evict_ready), 576'(i != 1));
         cyc();
      end
      chk("t2_occ", 576'(occupancy),   576'(0));
      chk("t2_we0", 576'(vc_write_en), 576'(0));

      // 3: enqueue and drain on the same edge, six entries across the wrap
      drained.delete();
      vc_hold = 1'b1;
      enq(TAG_W'('h11), 6'd1, mk_data(TAG_W'('h11)));
      enq(TAG_W'('h12), 6'd2, mk_data(TAG_W'('h12)));
      chk("t3_occ2", 576'(occupancy), 576'(2));
      vc_hold = 1'b0;
      for (int i = 3; i <= 6; i++) begin
         evict_valid = 1'b1;
         evict_tag   = TAG_W'('h10 + i);
         evict_index = IDX_W'(i);
         evict_data  = mk_data(TAG_W'('h10 + i));
         cyc();
         chk("t3_occ_steady", 576'(occupancy), 576'(2));
      end
      evict_valid = 1'b0;
      cyc(); cyc();
      chk("t3_occ_empty", 576'(occupancy), 576'(0));
      chk("t3_ndrain", 576'(drained.size()), 576'(6));
      for (int i = 0; i < 6 && i < drained.size(); i++)
         chk("t3_order", 576'(drained[i]), 576'('h11 + i));

      // 4: asynchronous reset mid-cycle at count 3
      vc_hold = 1'b1;
      for (int i = 1; i <= 3; i++) enq(TAG_W'('h30 + i), IDX_W'(i), mk_data(TAG_W'('h30 + i)));
      chk("t4_occ3", 576'(occupancy), 576'(3));
      #2;
      vc_hold = 1'b0;
      reset   = 1'b1;
      #1;
      chk("t4_occ_now",   576'(occupancy),   576'(0));
      chk("t4_we_now",    576'(vc_write_en), 576'(0));
      chk("t4_tag_now",   576'(vc_tag),      576'(0));
      chk("t4_data_now",  576'(vc_data),     576'(0));
      chk("t4_ready_now", 576'(evict_ready), 576'(0));
      cyc();
      reset = 1'b0;
      cyc();
      chk("t4_ready_after", 576'(evict_ready), 576'(1));
      chk("t4_occ_after",   576'(occupancy),   576'(0));

      // 5: flush with a concurrent enqueue at count 2
      vc_hold = 1'b1;
      enq(TAG_W'('h41), 6'd1, mk_data(TAG_W'('h41)));
      enq(TAG_W'('h42), 6'd2, mk_data(TAG_W'('h42)));
      chk("t5_occ2", 576'(occupancy), 576'(2));
      drained.delete();
      flush       = 1'b1;
      vc_hold     = 1'b0;
      evict_valid = 1'b1;
      evict_tag   = TAG_W'('h43);
      evict_index = 6'd3;
      evict_data  = mk_data(TAG_W'('h43));
      #1;
      chk("t5_we_flush", 576'(vc_write_en), 576'(0));
      cyc();
      flush       = 1'b0;
      evict_valid = 1'b0;
      #1;
      chk("t5_occ0", 576'(occupancy),   576'(0));
      chk("t5_we0",  576'(vc_write_en), 576'(0));
      cyc(); cyc(); cyc();
      chk("t5_ndrain", 576'(drained.size()), 576'(0));

      // 6: bypass lookup, youngest duplicate wins
      vc_hold = 1'b1;
      d = '0; d[47:40] = 8'h11;
      enq(TAG_W'('hA), 6'd3, d);
      d = '0; d[47:40] = 8'h22;
      enq(TAG_W'('hA), 6'd3, d);
      lk_tag    = TAG_W'('hA);
      lk_index  = 6'd3;
      lk_offset = 6'd5;
      #1;
`ifdef VFB_BYPASS_EN
      chk("t6_hit",  576'(lk_hit),  576'(1));
      chk("t6_byte", 576'(lk_byte), 576'('h22));
`else
      chk("t6_hit_off",  576'(lk_hit),  576'(0));
      chk("t6_byte_off", 576'(lk_byte), 576'(0));
`endif
      lk_tag = TAG_W'('hB);
      #1;
      chk("t6_miss_hit",  576'(lk_hit),  576'(0));
      chk("t6_miss_byte", 576'(lk_byte), 576'(0));
      cyc();
      vc_hold = 1'b0;
      cyc(); cyc(); cyc();
      chk("t6_occ_end", 576'(occupancy), 576'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
